// File: rtl/ahb_lite_slave_mem_pkg.sv
// rtl/ahb_lite_slave_mem_pkg.sv - shared AHB-Lite encodings and slave FSM state type
package ahb_lite_slave_mem_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_LAST,
        ST_ERR1,
        ST_ERR2
    } slv_state_t;

endpackage

// File: rtl/ahb_lite_slave_mem_byte_lane_gen.sv
// rtl/ahb_lite_slave_mem_byte_lane_gen.sv - HSIZE/addr to byte enables plus size/alignment error
module ahb_byte_lane_gen
    import ahb_lite_slave_mem_pkg::*;
(
    input  logic [2:0] i_size,
    input  logic [1:0] i_addr,
    output logic [3:0] o_byte_en,
    output logic       o_err
);

    // Illegal sizes are folded into the error flag so callers need one check
    always_comb begin
        o_byte_en = 4'b0000;
        o_err     = 1'b0;
        case (i_size)
            HSIZE_BYTE: o_byte_en = 4'b0001 << i_addr;
            HSIZE_HALF: begin
                o_byte_en = i_addr[1] ? 4'b1100 : 4'b0011;
                o_err     = i_addr[0];
            end
            HSIZE_WORD: begin
                o_byte_en = 4'b1111;
                o_err     = |i_addr;
            end
            default:    o_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/ahb_lite_slave_mem.sv
// rtl/ahb_lite_slave_mem.sv - AHB-Lite SRAM slave with wait states and two-cycle ERROR
module ahb_lite_slave_mem
    import ahb_lite_slave_mem_pkg::*;
#(
    parameter int MEM_DEPTH   = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam int         IDX_W         = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0] WAIT_CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [31:0]      r_mem [MEM_DEPTH];
    slv_state_t       r_state;
    slv_state_t       w_next;
    logic [3:0]       r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic             r_write;
    logic [3:0]       r_be;

    htrans_t          w_htrans;
    logic [3:0]       w_be;
    logic             w_lane_err;
    logic             w_valid;
    logic             w_err;
    logic             w_capture;
    logic             w_unused;

    ahb_byte_lane_gen u_lane_gen (
        .i_size    (HSIZE),
        .i_addr    (HADDR[1:0]),
        .o_byte_en (w_be),
        .o_err     (w_lane_err)
    );

    assign w_htrans  = htrans_t'(HTRANS);
    assign w_valid   = HSEL & HREADY & ((w_htrans == HTRANS_NONSEQ) | (w_htrans == HTRANS_SEQ));
    assign w_err     = w_lane_err | ({1'b0, HADDR[7:2]} >= 7'(MEM_DEPTH));
    // Only accept a new address phase while this slave is itself signalling ready
    assign w_capture = w_valid & (r_state != ST_WAIT) & (r_state != ST_ERR1);
    assign w_unused  = ^HADDR[31:8];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_write <= 1'b0;
            r_be    <= 4'd0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_capture) begin
                r_idx   <= HADDR[IDX_W+1:2];
                r_write <= HWRITE;
                r_be    <= w_be;
                r_cnt   <= WAIT_CNT_INIT;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_WAIT: if (r_cnt == 4'd0) w_next = ST_LAST;
            ST_ERR1: w_next = ST_ERR2;
            default: begin
                if (!w_valid) begin
                    w_next = ST_IDLE;
                end else if (w_err) begin
                    w_next = ST_ERR1;
                end else if (WAIT_STATES > 0) begin
                    w_next = ST_WAIT;
                end else begin
                    w_next = ST_LAST;
                end
            end
        endcase
    end

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        HRDATA    = 32'd0;
        case (r_state)
            ST_WAIT: begin
                HREADYOUT = 1'b0;
                HRDATA    = r_mem[r_idx];
            end
            ST_LAST: HRDATA = r_mem[r_idx];
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
            end
            ST_ERR2: HRESP = HRESP_ERROR;
            default: ;
        endcase
    end

    // Commit happens on the edge that ends LAST, so a pipelined read sees it next cycle
    always_ff @(posedge HCLK) begin
        if ((r_state == ST_LAST) && r_write) begin
            for (int k = 0; k < 4; k++) begin
                if (r_be[k]) begin
                    r_mem[r_idx][8*k +: 8] <= HWDATA[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: doc/ahb_lite_slave_mem.md
Name: ahb_lite_slave_mem

Overview:
AHB-Lite responder: a word-addressed SRAM slave that answers the HSEL produced by the address decoder. It captures address-phase controls, inserts a configurable number of wait states, and performs byte/halfword/word reads and writes. It returns OKAY or a two-cycle ERROR on HREADYOUT/HRESP, which feed the slave-to-master response mux.

Parameters:
MEM_DEPTH, 64, number of 32-bit words; word index is HADDR[7:2], and MEM_DEPTH must be ≤ 64 so the slave fits its 256-byte HADDR[8] region.
WAIT_STATES, 0, extra data-phase cycles with HREADYOUT low per OKAY transfer (0..15).

Ports:
HCLK  input  1  system clock, rising edge
HRESETn  input  1  asynchronous active-low reset
HSEL  input  1  slave select from decoder
HADDR  input  32  address (bits [7:0] used; [8] already decoded)
HWRITE  input  1  1 = write, 0 = read
HSIZE  input  3  0 = byte, 1 = halfword, 2 = word; others illegal
HTRANS  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
HWDATA  input  32  write data (data phase)
HREADY  input  1  bus-level ready (muxed HREADYOUT of the active slave)
HRDATA  output  32  read data
HREADYOUT  output  1  this slave's ready
HRESP  output  1  0 = OKAY, 1 = ERROR

Behaviour:
- Reset (async, HRESETn=0): state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, captured controls cleared. Memory contents are not reset. Reset mid-transfer abandons the transfer with no memory write.
- Valid address phase: HSEL & HREADY & HTRANS[1] at a rising edge. The slave captures HADDR[7:0], HWRITE and HSIZE. IDLE/BUSY or HSEL=0 (with HREADY=1) leaves the slave in or returns it to IDLE, with zero-wait OKAY.
- Error check at capture:
  - HSIZE>2, or
  - misalignment (halfword with HADDR[0]=1; word with HADDR[1:0]≠0), or
  - word index ≥ MEM_DEPTH.
- FSM states: IDLE, WAIT, LAST, ERR1, ERR2.
- Transitions:
  - IDLE: valid & error → ERR1; valid & WAIT_STATES>0 → WAIT (counter loaded with WAIT_STATES−1); valid & WAIT_STATES=0 → LAST.
  - WAIT: HREADYOUT=0, HRESP=0; counter decrements; at 0 → LAST.
  - LAST: HREADYOUT=1, HRESP=0, transfer completes. A new valid address phase in the same cycle (pipelining) goes to ERR1/WAIT/LAST per the rules above; otherwise → IDLE.
  - ERR1: HREADYOUT=0, HRESP=1 → ERR2.
  - ERR2: HREADYOUT=1, HRESP=1; next state is evaluated as in LAST. Errored transfers never touch memory. ERROR is exactly two cycles regardless of WAIT_STATES.
- Write: memory is updated at the rising edge ending LAST. Only the byte lanes selected by HSIZE and captured HADDR[1:0] are written from the matching HWDATA lanes (little-endian: lane k = bits [8k+7:8k]).
- Read: in WAIT and LAST, HRDATA = mem[captured index], full word, combinational from the array; lanes are not masked. In all other states HRDATA=0.
- Latency with WAIT_STATES=N: N+1 data-phase cycles per OKAY transfer; back-to-back throughput is one transfer per N+1 cycles.
- Back-to-back write→read to the same address: the write commits at the edge ending its LAST, so the following read's data phase returns the new value with no forwarding logic.
- HSEL deasserted mid-data-phase does not abort; the data phase always completes.

Decomposition:
- Shared package Definitions holds:
  - htrans_t enum (IDLE, BUSY, NONSEQ, SEQ);
  - hsize constants BYTE/HALF/WORD;
  - HRESP_OKAY/HRESP_ERROR;
  - slave FSM state enum.
- One sub-module is natural: ahb_byte_lane_gen (HSIZE + addr[1:0] → 4-bit byte-enable and align-error flag), combinational, reusable by other slaves.

Test Plan:
- Reset, then idle: HRESETn low for 2 cycles → HREADYOUT=1, HRESP=0, HRDATA=0; HSEL=1, HTRANS=IDLE → stays OKAY, no wait.
- WAIT_STATES=0: word write 0xDEADBEEF at 0x10, then pipelined word read at 0x10 → read data phase HRDATA=0xDEADBEEF, HREADYOUT=1 every cycle.
- Byte lanes: word 0x00000000 at 0x20, byte write 0xAA at 0x21, halfword write 0x1234 at 0x22 → word read returns 0x1234AA00.
- WAIT_STATES=2: single read → HREADYOUT low for exactly 2 cycles, then high with valid data; back-to-back reads complete every 3 cycles.
- Errors:
  - word access at 0x02 → HRESP=1/HREADYOUT=0, then HRESP=1/HREADYOUT=1, memory unchanged;
  - same for index ≥ MEM_DEPTH (MEM_DEPTH=16, HADDR=0x40) and HSIZE=3.
- Reset mid-WAIT (WAIT_STATES=3, write in progress) → outputs return to reset values immediately; target word keeps its old contents.
